// File: rtl/sha256_pkg.sv
// sha256_pkg: shared SHA-256 constants and helpers for the step_three
// compression stage.
//   K         round constants K[0..63]
//   IV256     SHA-256 initial hash value, H0 in [255:224] down to H7 in [31:0]
//   IV224     SHA-224 initial hash value, same packing
//   bsig0/1   the big sigma functions applied to a and e in each round
//   ssig0/1   the small sigma functions used by the schedule expansion
//   ch, maj   round choice / majority functions
//   state_t   compression FSM states
package sha256_pkg;

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROUND,
    ST_UPDATE
  } state_t;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (~x & z);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
    return (x & y) ^ (x & z) ^ (y & z);
  endfunction

endpackage

// File: rtl/step_three_sched.sv
// step_three_sched: 16-word sliding message-schedule window.
//   clk    rising-edge clock
//   load   capture a new block (W0 at [511:480] .. W15 at [31:0])
//   shift  advance one round: drop W[t], append W[t+16]
//   block  incoming 512-bit block
//   wt     schedule word for the current round
// The window always holds W[t..t+15], so Wt is simply the oldest entry;
// the expanded word computed each round is W[t+16], which for t>=16 has
// already become the word at the head by the time it is consumed.
module step_three_sched
  import sha256_pkg::*;
(
  input  logic         clk,
  input  logic         load,
  input  logic         shift,
  input  logic [511:0] block,
  output logic [31:0]  wt
);

  logic [31:0] win [16];
  logic [31:0] w_next;

  assign w_next = ssig1(win[14]) + win[9] + ssig0(win[1]) + win[0];
  assign wt     = win[0];

  // Window is pure data: its contents are only meaningful after a load.
  always_ff @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) win[i] <= block[511 - 32*i -: 32];
    end else if (shift) begin
      for (int i = 0; i < 15; i++) win[i] <= win[i+1];
      win[15] <= w_next;
    end
  end

endmodule

// File: rtl/step_three.sv
// step_three: SHA-256 compression stage. Accepts one 16-word block over
// valid/ready, runs ROUNDS rounds (one per clock), folds the working
// variables into H0..H7 and, for the last block of a message, presents
// the digest with a one-cycle o_valid pulse.
//   i_clk     clock
//   i_reset   asynchronous active-low reset
//   i_valid   block present on i_w        o_ready  idle, can accept
//   i_first   first block of a message    i_last   final block
//   i_w       W0 at [511:480] .. W15 at [31:0]
//   o_valid   new digest pulse            o_digest H0 at [255:224] .. H7
// Optional feature: define STEP_THREE_SHA224_EN to add i_sha224 (sampled
// with i_first) selecting the SHA-224 IV and zeroing o_digest[31:0].
module step_three
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic         i_first,
  input  logic         i_last,
`ifdef STEP_THREE_SHA224_EN
  input  logic         i_sha224,
`endif
  input  logic [511:0] i_w,
  output logic         o_valid,
  output logic [255:0] o_digest
);

  localparam logic [6:0] LAST_T = 7'(ROUNDS - 1);

  state_t       state_q, state_d;
  logic [6:0]   t_q;
  logic         last_q;
  logic [31:0]  h_q   [8];
  logic [31:0]  wv_q  [8];
  logic [31:0]  wv_d  [8];
  logic [31:0]  h_sum [8];
  logic [31:0]  wt;
  logic [31:0]  t1, t2;
  logic [255:0] iv_sel;
  logic [255:0] digest_next;
  logic         accept;

`ifdef STEP_THREE_SHA224_EN
  logic sha224_q;
  assign iv_sel = i_sha224 ? IV224 : IV256;
`else
  assign iv_sel = IV256;
`endif

  assign o_ready = (state_q == ST_IDLE);
  assign accept  = o_ready && i_valid;

  step_three_sched u_sched (
    .clk   (i_clk),
    .load  (accept),
    .shift (state_q == ST_ROUND),
    .block (i_w),
    .wt    (wt)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (i_valid) state_d = ST_ROUND;
      ST_ROUND:  if (t_q == LAST_T) state_d = ST_UPDATE;
      ST_UPDATE: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Round datapath: working variables a..h live in wv_q[0..7].
  always_comb begin
    t1 = wv_q[7] + bsig1(wv_q[4]) + ch(wv_q[4], wv_q[5], wv_q[6]) + K[t_q[5:0]] + wt;
    t2 = bsig0(wv_q[0]) + maj(wv_q[0], wv_q[1], wv_q[2]);
    wv_d[0] = t1 + t2;
    wv_d[1] = wv_q[0];
    wv_d[2] = wv_q[1];
    wv_d[3] = wv_q[2];
    wv_d[4] = wv_q[3] + t1;
    wv_d[5] = wv_q[4];
    wv_d[6] = wv_q[5];
    wv_d[7] = wv_q[6];
  end

  always_comb begin
    digest_next = '0;
    for (int i = 0; i < 8; i++) begin
      h_sum[i] = h_q[i] + wv_q[i];
      digest_next[255 - 32*i -: 32] = h_sum[i];
    end
`ifdef STEP_THREE_SHA224_EN
    // SHA-224 publishes only H0..H6.
    if (sha224_q) digest_next[31:0] = '0;
`endif
  end

  // Control and chaining state: cleared by reset so an aborted block
  // leaves no trace.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q  <= ST_IDLE;
      t_q      <= '0;
      last_q   <= 1'b0;
      o_valid  <= 1'b0;
      o_digest <= '0;
      for (int i = 0; i < 8; i++) h_q[i] <= IV256[255 - 32*i -: 32];
`ifdef STEP_THREE_SHA224_EN
      sha224_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      o_valid <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            t_q    <= '0;
            last_q <= i_last;
            if (i_first) begin
              for (int i = 0; i < 8; i++) h_q[i] <= iv_sel[255 - 32*i -: 32];
`ifdef STEP_THREE_SHA224_EN
              sha224_q <= i_sha224;
`endif
            end
          end
        end
        ST_ROUND: t_q <= t_q + 7'd1;
        ST_UPDATE: begin
          for (int i = 0; i < 8; i++) h_q[i] <= h_sum[i];
          if (last_q) begin
            o_digest <= digest_next;
            o_valid  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  // Working variables are data only: seeded on acceptance, then rounds.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      for (int i = 0; i < 8; i++)
        wv_q[i] <= i_first ? iv_sel[255 - 32*i -: 32] : h_q[i];
    end else if (state_q == ST_ROUND) begin
      wv_q <= wv_d;
    end
  end

endmodule
